// File: rtl/pc_next_pkg.sv
// pc_next_pkg: condition codes, flag bit indices and FSM encoding shared by the PC logic.
package pc_next_pkg;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;
  typedef enum logic {S_IDLE, S_COMMIT} state_e;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational condition-code resolution against {N,Z,F,L,C}.
module cond_eval
  import pc_next_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       true
);
  logic n, z, f, l, c;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign f = flags[FLAG_F];
  assign l = flags[FLAG_L];
  assign c = flags[FLAG_C];
  always_comb begin
    true = 1'b0;
    case (cond)
      COND_EQ: true = z;
      COND_NE: true = !z;
      COND_CS: true = c;
      COND_CC: true = !c;
      COND_HI: true = l;
      COND_LS: true = !l;
      COND_GT: true = n;
      COND_LE: true = !n;
      COND_FS: true = f;
      COND_FC: true = !f;
      COND_LO: true = !l && !z;
      COND_HS: true = l || z;
      COND_LT: true = !n && !z;
      COND_GE: true = n || z;
      COND_UC: true = 1'b1;
      default: true = 1'b0;
    endcase
  end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC owner resolving sequential, Bcond, Jcond and JAL next-PC.
// Optional branch statistics counters under `PC_BRANCH_STATS_EN.
module pc_next_unit
  import pc_next_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              branch,
  input  logic              jump,
  input  logic              link,
  input  logic [15:0]       instr,
  input  logic [4:0]        flags,
  input  logic [15:0]       rtarget,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       link_val,
  output logic              link_we,
  output logic              taken,
  output logic              redirect,
`ifdef PC_BRANCH_STATS_EN
  output logic [15:0]       br_taken_cnt,
  output logic [15:0]       br_ntaken_cnt,
`endif
  output logic              err
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, disp;
  logic [15:0]       link_val_q, link_val_d;
  logic              link_we_q, link_we_d, taken_q, taken_d;
  logic              redirect_q, redirect_d, err_q, err_d;
  logic              cond_ok, is_jal, redir;
  logic              unused_bits;
  assign unused_bits = ^{instr[15:12], rtarget};
  cond_eval u_cond (.cond(instr[11:8]), .flags(flags), .true(cond_ok));
  assign pc_inc = pc_q + 1'b1;
  assign disp   = ADDR_W'($signed(instr[7:0]));
  assign is_jal = jump & link;
  // jump wins over branch when both are asserted
  assign redir  = jump ? (link | cond_ok) : (branch & cond_ok);
  always_comb begin
    state_d    = pc_en ? S_COMMIT : S_IDLE;
    pc_d       = !pc_en ? pc_q : (jump && redir) ? rtarget[ADDR_W-1:0] :
                 redir ? pc_q + disp : pc_inc;
    link_val_d = (pc_en && is_jal) ? 16'(pc_inc) : link_val_q;
    link_we_d  = pc_en & is_jal;
    redirect_d = pc_en & redir;
    taken_d    = pc_en ? redir : taken_q;
    err_d      = err_q | (pc_en & branch & jump);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      link_val_q <= '0;
      link_we_q  <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      link_val_q <= link_val_d;
      link_we_q  <= link_we_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      err_q      <= err_d;
    end
  end
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] tk_q, tk_d, ntk_q, ntk_d;
  logic        counted;
  assign counted = pc_en & (branch | jump) & !is_jal;
  always_comb begin
    tk_d  = (counted && redir && tk_q != 16'hFFFF) ? tk_q + 16'd1 : tk_q;
    ntk_d = (counted && !redir && ntk_q != 16'hFFFF) ? ntk_q + 16'd1 : ntk_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tk_q  <= '0;
      ntk_q <= '0;
    end else begin
      tk_q  <= tk_d;
      ntk_q <= ntk_d;
    end
  end
  assign br_taken_cnt  = tk_q;
  assign br_ntaken_cnt = ntk_q;
`endif
  assign pc       = pc_q;
  assign link_val = link_val_q;
  assign link_we  = link_we_q;
  assign taken    = taken_q;
  assign redirect = redirect_q;
  assign err      = err_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed vectors with hand-computed expectations for pc_next_unit.
module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_en = 1'b0, branch = 1'b0, jump = 1'b0, link = 1'b0;
  logic [15:0] instr = '0, rtarget = '0;
  logic [4:0]  flags = '0;
  logic [15:0] pc, link_val;
  logic        link_we, taken, redirect, err;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] br_taken_cnt, br_ntaken_cnt;
`endif
  int total = 0, bad = 0;

  pc_next_unit #(.ADDR_W(16), .RESET_PC(16'h0010)) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .branch(branch), .jump(jump), .link(link),
    .instr(instr), .flags(flags), .rtarget(rtarget), .pc(pc), .link_val(link_val),
    .link_we(link_we), .taken(taken), .redirect(redirect),
`ifdef PC_BRANCH_STATS_EN
    .br_taken_cnt(br_taken_cnt), .br_ntaken_cnt(br_ntaken_cnt),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic commit(input logic b, input logic j, input logic l, input logic [15:0] ins,
                        input logic [4:0] fl, input logic [15:0] rt);
    @(negedge clk);
    pc_en = 1'b1; branch = b; jump = j; link = l; instr = ins; flags = fl; rtarget = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic b, input logic j, input logic l);
    @(negedge clk);
    pc_en = 1'b0; branch = b; jump = j; link = l; instr = $urandom; flags = $urandom; rtarget = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    commit(1'b0, 1'b1, 1'b0, 16'h0E00, 5'd0, v);
    idle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pc_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pc", pc, 16'h0010);
    chk("rst_outs", {link_val, link_we, taken, redirect, err}, '0);
    @(negedge clk);
    rst = 1'b0; pc_en = 1'b0;

    commit(1'b0, 1'b0, 1'b0, 16'h0E00, 5'h1F, 16'hAAAA);
    chk("seq1_pc", pc, 16'h0011);
    commit(1'b0, 1'b0, 1'b0, 16'h0E00, 5'h1F, 16'hAAAA);
    chk("seq2_pc", pc, 16'h0012);
    commit(1'b0, 1'b0, 1'b0, 16'h0E00, 5'h1F, 16'hAAAA);
    chk("seq3_pc", pc, 16'h0013);
    chk("seq_tk_rd", {taken, redirect}, 2'b00);

    idle(1'b1, 1'b1, 1'b1);
    chk("ignored_pc", pc, 16'h0013);
    chk("ignored_outs", {link_we, taken, redirect, err}, 4'b0000);

    set_pc(16'h0020);
    chk("setpc_rd_off", {taken, redirect}, 2'b10);
    commit(1'b1, 1'b0, 1'b0, 16'hC0FE, 5'b01000, 16'h0);
    chk("beq_t_pc", pc, 16'h001E);
    chk("beq_t_tk_rd", {taken, redirect}, 2'b11);
    idle(1'b0, 1'b0, 1'b0);
    chk("beq_t_rd_pulse", {taken, redirect}, 2'b10);
    set_pc(16'h0020);
    commit(1'b1, 1'b0, 1'b0, 16'hC0FE, 5'b00000, 16'h0);
    chk("beq_nt_pc", pc, 16'h0021);
    chk("beq_nt_tk_rd", {taken, redirect}, 2'b00);

    set_pc(16'h0040);
    commit(1'b0, 1'b1, 1'b0, 16'h0C00, 5'b00000, 16'h1234);
    chk("jlt_t_pc", pc, 16'h1234);
    chk("jlt_t_tk", taken, 1'b1);
    set_pc(16'h0040);
    commit(1'b0, 1'b1, 1'b0, 16'h0C00, 5'b10000, 16'h1234);
    chk("jlt_nt_pc", pc, 16'h0041);
    chk("jlt_nt_tk", taken, 1'b0);

    set_pc(16'h0100);
    chk("pre_jal_lwe", link_we, 1'b0);
    commit(1'b0, 1'b1, 1'b1, 16'h0F00, 5'b00000, 16'h0200);
    chk("jal_pc", pc, 16'h0200);
    chk("jal_lval", link_val, 16'h0101);
    chk("jal_lwe", link_we, 1'b1);
    idle(1'b0, 1'b0, 1'b0);
    chk("jal_lwe_pulse", link_we, 1'b0);
    chk("jal_lval_hold", link_val, 16'h0101);

    set_pc(16'hFFFF);
    commit(1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 16'h0);
    chk("wrap_pc", pc, 16'h0000);
    commit(1'b1, 1'b0, 1'b0, 16'h0EFE, 5'b00000, 16'h0);
    chk("neg_wrap_pc", pc, 16'hFFFE);
    chk("err_clear", err, 1'b0);
    commit(1'b1, 1'b1, 1'b0, 16'h0E00, 5'b00000, 16'h0055);
    chk("both_pc", pc, 16'h0055);
    chk("both_err", err, 1'b1);
    idle(1'b0, 1'b0, 1'b0);
    commit(1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 16'h0);
    chk("err_sticky", err, 1'b1);

    @(negedge clk);
    rst = 1'b1; pc_en = 1'b1; branch = 1'b1; jump = 1'b0; link = 1'b0; instr = 16'h0E05;
    @(posedge clk);
    #1;
    chk("rst_br_pc", pc, 16'h0010);
    chk("rst_br_outs", {link_val, link_we, taken, redirect, err}, '0);
    @(negedge clk);
    rst = 1'b0; pc_en = 1'b0;

`ifdef PC_BRANCH_STATS_EN
    chk("stats_rst", {br_taken_cnt, br_ntaken_cnt}, 32'h0);
    repeat (3) commit(1'b1, 1'b0, 1'b0, 16'h0E01, 5'b00000, 16'h0);
    repeat (2) commit(1'b1, 1'b0, 1'b0, 16'h0F01, 5'b00000, 16'h0);
    commit(1'b0, 1'b1, 1'b1, 16'h0E00, 5'b00000, 16'h0300);
    idle(1'b0, 1'b0, 1'b0);
    chk("stats_taken", br_taken_cnt, 16'd3);
    chk("stats_ntaken", br_ntaken_cnt, 16'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
